// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU. add/sub/mov resolve in one CALC cycle, while
//            mul (shift-add) and div/mod (restoring) iterate one bit per
//            cycle for N cycles. The result and flags are registered on
//            entry to DONE and held until the next DONE.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] resultado,
  output logic [3:0]   flagsResult
);

  localparam int FLAGS_W = 4;
  localparam int CNT_W   = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Operands captured at the start edge; later input changes are ignored.
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [2:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;

  // Shift-add multiplier: {r_mhi, r_mlo} becomes the 2N-bit product;
  // r_mlo starts as the multiplier and is consumed LSB first.
  logic [N-1:0]       r_mhi;
  logic [N-1:0]       r_mlo;
  // Restoring divider: r_dq starts as the dividend and fills with quotient bits.
  logic [N-1:0]       r_rem;
  logic [N-1:0]       r_dq;

  logic [N:0]         w_madd;
  logic [N-1:0]       w_mhi_nx;
  logic [N-1:0]       w_mlo_nx;
  logic [N:0]         w_dsh;
  logic [N-1:0]       w_dsub;
  logic               w_dge;
  logic [N-1:0]       w_rem_nx;
  logic [N-1:0]       w_dq_nx;

  logic               w_iter;
  logic               w_last;
  logic [N:0]         w_sum;
  logic [N-1:0]       w_diff;
  logic [N-1:0]       w_res;
  logic               w_c;
  logic               w_v;
  logic [FLAGS_W-1:0] w_flags;

  // One iteration step of the multiplier and divider datapaths.
  always_comb begin
    w_madd   = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_a} : {(N+1){1'b0}});
    w_mhi_nx = w_madd[N:1];
    w_mlo_nx = {w_madd[0], r_mlo[N-1:1]};

    w_dsh    = {r_rem, r_dq[N-1]};
    w_dge    = (w_dsh >= {1'b0, r_b});
    w_dsub   = w_dsh[N-1:0] - r_b;
    w_rem_nx = w_dge ? w_dsub : w_dsh[N-1:0];
    w_dq_nx  = {r_dq[N-2:0], w_dge};
  end

  // Result and flag selection; evaluated on the final CALC cycle.
  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_diff = r_a - r_b;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (r_a >= r_b);
        w_v   = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);
      end
      OP_MUL: begin
        w_res = w_mlo_nx;
        w_c   = |w_mhi_nx;
        w_v   = |w_mhi_nx;
      end
      OP_DIV: begin
        // Divide by zero saturates to all-ones and raises V.
        w_res = (r_b == '0) ? {N{1'b1}} : w_dq_nx;
        w_v   = (r_b == '0);
      end
      OP_MOD: begin
        // Modulo by zero returns the dividend and raises V.
        w_res = (r_b == '0) ? r_a : w_rem_nx;
        w_v   = (r_b == '0);
      end
      OP_MOV: begin
        w_res = r_b;
      end
      default: begin
        w_res = '0;
        w_v   = 1'b1;
      end
    endcase
    w_flags = {w_res[N-1], (w_res == '0), w_c, w_v};
  end

  assign w_iter = (r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_MOD);
  assign w_last = !w_iter || (r_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_mhi       <= '0;
      r_mlo       <= '0;
      r_rem       <= '0;
      r_dq        <= '0;
      resultado   <= '0;
      flagsResult <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= ALUControl;
        r_cnt <= CNT_W'(N - 1);
        r_mhi <= '0;
        r_mlo <= b;
        r_rem <= '0;
        r_dq  <= a;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - 1'b1;
        r_mhi <= w_mhi_nx;
        r_mlo <= w_mlo_nx;
        r_rem <= w_rem_nx;
        r_dq  <= w_dq_nx;
        if (w_last) begin
          resultado   <= w_res;
          flagsResult <= w_flags;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (N=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic [3:0]   flg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (op),
    .busy       (busy),
    .done       (done),
    .resultado  (res),
    .flagsResult(flg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE, scrambles the inputs right after the
  // start edge, and returns the done latency (start edge = 1) and busy count.
  // Returns with the DUT back in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        output int lat, output int bcnt);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; a = ~x; b = y ^ 32'hA5A5_5A5A; op = 3'b101;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 200; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic op_check(input string tag, input logic [2:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input int elat,
                          input logic [N-1:0] eres, input logic [3:0] eflg);
    int lat, bcnt;
    run_op(o, x, y, lat, bcnt);
    check({tag, "_lat"},   64'(lat),  64'(elat));
    check({tag, "_busy"},  64'(bcnt), 64'(elat - 1));
    check({tag, "_res"},   64'(res),  64'(eres));
    check({tag, "_flags"}, 64'(flg),  64'(eflg));
  endtask

  initial begin
    int lat, dc, d1, d2, idl;
    rst = 1'b1; start = 1'b1; a = 32'h1; b = 32'h1; op = 3'b000;
    step(); step(); step();
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_res",   64'(res),  64'(0));
    check("rst_flags", 64'(flg),  64'(0));
    rst = 1'b0; start = 1'b0;

    op_check("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h1,         2,  32'h0,         4'b0110);
    op_check("add_ovf",   3'b000, 32'h7FFF_FFFF, 32'h1,         2,  32'h8000_0000, 4'b1001);
    op_check("sub_ovf",   3'b001, 32'h8000_0000, 32'h1,         2,  32'h7FFF_FFFF, 4'b0011);
    op_check("sub_borrow",3'b001, 32'h5,         32'h7,         2,  32'hFFFF_FFFE, 4'b1000);
    op_check("sub_zero",  3'b001, 32'h3,         32'h3,         2,  32'h0,         4'b0110);
    op_check("mul_hi",    3'b010, 32'h0001_0000, 32'h0001_0000, 33, 32'h0,         4'b0111);
    op_check("mul_small", 3'b010, 32'h7,         32'h6,         33, 32'h2A,        4'b0000);
    op_check("mul_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,         4'b0011);
    op_check("div_zero",  3'b011, 32'h7,         32'h0,         33, 32'hFFFF_FFFF, 4'b1001);
    op_check("mod_zero",  3'b100, 32'h7,         32'h0,         33, 32'h7,         4'b0001);
    op_check("div",       3'b011, 32'd100,       32'd7,         33, 32'd14,        4'b0000);
    op_check("div_max",   3'b011, 32'hFFFF_FFFF, 32'h1,         33, 32'hFFFF_FFFF, 4'b1000);
    op_check("mod",       3'b100, 32'd100,       32'd7,         33, 32'd2,         4'b0000);
    op_check("illegal",   3'b111, 32'h12,        32'h34,        2,  32'h0,         4'b0101);
    op_check("mod_keep",  3'b100, 32'd100,       32'd7,         33, 32'd2,         4'b0000);
    check("hold_idle_res", 64'(res), 64'(2));

    // Reset in the 10th CALC cycle of a divide.
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 10; k++) step();
    check("mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy",  64'(busy), 64'(0));
    check("abort_done",  64'(done), 64'(0));
    check("abort_res",   64'(res),  64'(0));
    check("abort_flags", 64'(flg),  64'(0));
    dc = 0;
    repeat (40) begin
      step();
      if (done) dc++;
    end
    check("abort_no_done", 64'(dc), 64'(0));
    op_check("mov_after_rst", 3'b101, 32'h77, 32'h5A, 2, 32'h5A, 4'b0000);

    // Second start during a multiply must be ignored.
    op = 3'b010; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k >= 4 && k <= 8) begin
        start = 1'b1; a = 32'd9; b = 32'd9; op = 3'b000;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("busy_start_lat", 64'(lat), 64'(33));
    check("busy_start_res", 64'(res), 64'(15));
    check("busy_start_flg", 64'(flg), 64'(0));
    step(); step();
    check("busy_start_idle", 64'(busy), 64'(0));

    // Held start: back-to-back adds separated by a single IDLE cycle.
    op = 3'b000; a = 32'd1; b = 32'd2; start = 1'b1;
    step();
    d1 = -1; d2 = -1; idl = 0;
    for (int k = 1; k <= 12; k++) begin
      if (done) begin
        if (d1 < 0)      d1 = k;
        else if (d2 < 0) d2 = k;
      end else if (d1 >= 0 && d2 < 0 && !busy) begin
        idl++;
      end
      step();
    end
    start = 1'b0;
    repeat (5) step();
    check("b2b_first",   64'(d1),      64'(2));
    check("b2b_spacing", 64'(d2 - d1), 64'(3));
    check("b2b_idle",    64'(idl),     64'(1));
    check("b2b_res",     64'(res),     64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, operand and result width in bits, legal range 4..64.
REQ-002 The block SHALL have parameter FLAGS_W, fixed 4, flag vector width; not overridable.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port a, input, N, first operand, unsigned for mul/div/mod.
REQ-007 The block SHALL have port b, input, N, second operand.
REQ-008 The block SHALL have port ALUControl, input, 3, operation select: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 mov; 110/111 illegal.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when resultado and flagsResult become valid.
REQ-011 The block SHALL have port resultado, output, N, registered result.
REQ-012 The block SHALL have port flagsResult, output, 4, registered flags: bit3 N (result MSB), bit2 Z (result==0), bit1 C, bit0 V.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; reset SHALL enter IDLE.
REQ-014 In IDLE, start=1 SHALL latch a, b and ALUControl and move to CALC; start in CALC or DONE SHALL be ignored and SHALL NOT alter latched operands.
REQ-015 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE; DONE SHALL return to IDLE after one cycle.
REQ-016 add, sub, mov and illegal codes SHALL spend 1 cycle in CALC: done asserts 2 cycles after the start edge.
REQ-017 mul SHALL use iterative shift-add, one multiplier bit per cycle, spending N cycles in CALC: done asserts N+1 cycles after the start edge.
REQ-018 div and mod SHALL use iterative restoring division, one quotient bit per cycle, spending N cycles in CALC: done asserts N+1 cycles after the start edge.
REQ-019 add SHALL give a+b mod 2^N; C is the carry out; V is signed overflow.
REQ-020 sub SHALL give a-b mod 2^N; C=1 when a>=b unsigned (no borrow); V is signed overflow.
REQ-021 mul SHALL give the low N bits of the 2N-bit product; C=V=1 when the high N bits are nonzero, else 0.
REQ-022 div SHALL give floor(a/b); mod SHALL give a mod b; C=0 and V=0.
REQ-023 For div with b==0, the result SHALL be all-ones and V=1; for mod with b==0, the result SHALL be a and V=1. Latency SHALL be unchanged.
REQ-024 mov SHALL give b; C=0 and V=0.
REQ-025 Illegal codes SHALL give result 0 and flags 4'b0101 (Z=1, V=1).
REQ-026 N and Z SHALL always be derived from the final resultado value, for every operation.
REQ-027 resultado and flagsResult SHALL update only on entry to DONE and SHALL hold until the next DONE, including through IDLE.
REQ-028 Changes to inputs a, b or ALUControl after the start edge SHALL NOT affect the current result.
REQ-029 start held high continuously SHALL start a new operation on every IDLE cycle, giving back-to-back operations separated by the DONE cycle.

Reset
REQ-030 rst=1 SHALL force IDLE, busy=0, done=0, resultado=0 and flagsResult=0 at the next edge, from any state, including mid-mul or mid-div; an aborted operation SHALL produce no done pulse.
REQ-031 start asserted in the same cycle as rst SHALL be ignored.
REQ-032 After rst deasserts, the first start SHALL be accepted on the first IDLE cycle.

Verification
REQ-033 The bench SHALL cover add: N=32, a=0xFFFFFFFF, b=1 -> done at cycle 2, result 0, flags 4'b0110.
REQ-034 The bench SHALL cover sub: a=0x80000000, b=1 -> result 0x7FFFFFFF, flags 4'b0011.
REQ-035 The bench SHALL cover mul: a=0x00010000, b=0x00010000 -> busy for 32 cycles, done at cycle 33, result 0, flags 4'b0111.
REQ-036 The bench SHALL cover div by zero: div a=7, b=0 -> result 0xFFFFFFFF, flags 4'b1001; mod a=7, b=0 -> result 7, flags 4'b0001; div a=100, b=7 -> 14; mod a=100, b=7 -> 2.
REQ-037 The bench SHALL cover reset mid-operation: rst at CALC cycle 10 of a div -> all outputs 0 next cycle, no done pulse; a following mov with b=0x5A -> result 0x5A, flags 4'b0000.
REQ-038 The bench SHALL cover start during busy: a second start with different operands during a mul is ignored, and the first result is unchanged; held start gives back-to-back operations with done separated by exactly 1 IDLE cycle.
